mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply / divide unit.
//
// Mul: Booth-recoded shift-add. The default build is radix-2 and runs WIDTH
//      iterations. With BOOTH_RADIX4_EN defined it is radix-4 and runs
//      WIDTH/2 iterations; WIDTH must then be even. Both produce the same
//      full 2*WIDTH-bit signed product.
// Div: non-restoring division on operand magnitudes over WIDTH iterations.
//      One FIX cycle then restores the remainder and applies the signs.
//      Rc = {remainder, quotient}. The quotient truncates toward zero and
//      the remainder takes the sign of Ra. Divide by zero skips the
//      iterations and returns {Ra, all-ones} with div_zero raised.
//
// Ports:
//   clk      system clock, rising edge
//   clr      synchronous active-high reset
//   start    request, sampled only in IDLE
//   opcode   5'b01100 = Div, 5'b01101 = Mul; any other opcode is ignored
//   Ra, Rb   signed operands (dividend/multiplicand, divisor/multiplier)
//   Rc       registered 2*WIDTH-bit result
//   busy     high in MUL, DIV and FIX
//   done     one-cycle pulse in the cycle Rc takes a new result
//   div_zero set with done for a Div by zero, cleared by the next accepted start
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   Ra,
    input  logic [WIDTH-1:0]   Rb,
    output logic [2*WIDTH-1:0] Rc,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    localparam logic [4:0] OP_DIV = 5'b01100;
    localparam logic [4:0] OP_MUL = 5'b01101;
`ifdef BOOTH_RADIX4_EN
    localparam int MUL_ITERS = WIDTH / 2;
    localparam int AW        = WIDTH + 3;  // headroom for acc +/- 2*M
`else
    localparam int MUL_ITERS = WIDTH;
    localparam int AW        = WIDTH + 2;  // headroom for acc +/- M
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic          is_mul;
    logic          dz;

    // multiplier datapath: {acc, mq, qm1} is the Booth shift register
    logic signed [AW-1:0] acc, mcand, sum, acc_nxt;
    logic [WIDTH-1:0]     mq, mq_nxt;
    logic                 qm1, qm1_nxt;

    // divider datapath: rem carries a sign bit plus one guard bit
    logic [WIDTH+1:0] rem, shl, rem_nxt;
    logic [WIDTH-1:0] quo, dvs, quo_nxt, rem_mag;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q, neg_r;

    logic accept_mul, accept_div;

    assign accept_mul = (state == IDLE) && start && (opcode == OP_MUL);
    assign accept_div = (state == IDLE) && start && (opcode == OP_DIV);
    assign a_mag      = Ra[WIDTH-1] ? -Ra : Ra;
    assign b_mag      = Rb[WIDTH-1] ? -Rb : Rb;

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept_mul)      state_nxt = MUL;
                else if (accept_div) state_nxt = (Rb == '0) ? DONE : DIV;
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == CW'(MUL_ITERS - 1)) state_nxt = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- Booth step ----------------
    always_comb begin
        sum = acc;
`ifdef BOOTH_RADIX4_EN
        case ({mq[1:0], qm1})
            3'b001, 3'b010: sum = acc + mcand;
            3'b011:         sum = acc + (mcand <<< 1);
            3'b100:         sum = acc - (mcand <<< 1);
            3'b101, 3'b110: sum = acc - mcand;
            default:        sum = acc;
        endcase
        acc_nxt = sum >>> 2;
        mq_nxt  = {sum[1:0], mq[WIDTH-1:2]};
        qm1_nxt = mq[1];
`else
        case ({mq[0], qm1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_nxt = sum >>> 1;
        mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        qm1_nxt = mq[0];
`endif
    end

    // ---------------- non-restoring step ----------------
    always_comb begin
        shl     = {rem[WIDTH:0], quo[WIDTH-1]};
        rem_nxt = rem[WIDTH+1] ? (shl + {2'b00, dvs}) : (shl - {2'b00, dvs});
        quo_nxt = {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
        // a negative final partial remainder is one divisor short
        rem_mag = rem[WIDTH+1] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
    end

    // ---------------- state and datapath ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            Rc       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            is_mul   <= 1'b0;
            dz       <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            qm1      <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_mul || accept_div) begin
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        is_mul   <= accept_mul;
                        dz       <= accept_div && (Rb == '0);
                    end
                    if (accept_mul) begin
                        acc   <= '0;
                        mcand <= {{(AW-WIDTH){Ra[WIDTH-1]}}, Ra};
                        mq    <= Rb;
                        qm1   <= 1'b0;
                    end
                    if (accept_div) begin
                        if (Rb == '0) begin
                            // pre-load the divide-by-zero result
                            rem <= {2'b00, Ra};
                            quo <= '1;
                        end else begin
                            rem <= '0;
                            quo <= a_mag;
                        end
                        dvs   <= b_mag;
                        neg_q <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
                        neg_r <= Ra[WIDTH-1];
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    mq  <= mq_nxt;
                    qm1 <= qm1_nxt;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // the magnitude quotient of most-negative / -1 wraps back
                    // to most-negative here
                    quo <= neg_q ? -quo : quo;
                    rem <= {2'b00, (neg_r ? -rem_mag : rem_mag)};
                end
                DONE: begin
                    Rc       <= is_mul ? {acc[WIDTH-1:0], mq} : {rem[WIDTH-1:0], quo};
                    done     <= 1'b1;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32). Expected results come
// from plain signed 64-bit arithmetic, so they are independent of the
// Booth and non-restoring datapaths.
module tb_mul_div_unit;

    localparam int W = 32;
    localparam logic [4:0] OP_DIV = 5'b01100;
    localparam logic [4:0] OP_MUL = 5'b01101;
`ifdef BOOTH_RADIX4_EN
    localparam int MUL_LAT = W / 2 + 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 2;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           start = 1'b0;
    logic [4:0]     opcode = '0;
    logic [W-1:0]   Ra = '0, Rb = '0;
    logic [2*W-1:0] Rc;
    logic           busy, done, div_zero;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             n0 = 0;
    logic [2*W-1:0] last_rc = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode),
        .Ra(Ra), .Rb(Rb), .Rc(Rc), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) return sa * sb;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [31:0] b);
        if (op == OP_MUL) return MUL_LAT;
        return (b == 0) ? 1 : DIV_LAT;
    endfunction

    // Drive a request from a falling edge; returns #1 after the accepting
    // edge N with the inputs scrambled, since they must no longer matter.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        clr    = 1'b0;
        start  = 1'b1;
        opcode = op;
        Ra     = a;
        Rb     = b;
        @(posedge clk);
        #1;
        n0     = cyc;
        start  = 1'b0;
        opcode = 5'($urandom);
        Ra     = $urandom;
        Rb     = $urandom;
    endtask

    task automatic wait_done(input string tag);
        logic held = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk({tag, " rc_held"}, 64'(held), 64'd1);
                return;
            end
            if (Rc !== last_rc) held = 1'b0;
        end
        chk({tag, " timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int lat;
        exp = model(op, a, b);
        lat = latency(op, b);
        issue(op, a, b);
        if (lat > 1) chk({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(tag);
        chk({tag, " lat"}, 64'(cyc - n0), 64'(lat));
        chk({tag, " rc"}, Rc, exp);
        chk({tag, " dz"}, 64'(div_zero), 64'((op == OP_DIV) && (b == 0)));
        last_rc = exp;
        @(posedge clk);
        #1;
        chk({tag, " pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic ok;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst rc", Rc, 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst dz", 64'(div_zero), 64'd0);

        // directed cases
        run(OP_MUL, 32'd6, 32'd7, "mul 6*7");
        chk("mul 6*7 const", last_rc, 64'h0000_0000_0000_002A);
        run(OP_MUL, -32'sd3, 32'd5, "mul -3*5");
        chk("mul -3*5 const", Rc, 64'hFFFF_FFFF_FFFF_FFF1);
        run(OP_MUL, 32'h8000_0000, 32'h8000_0000, "mul minneg^2");
        chk("mul minneg const", Rc, 64'h4000_0000_0000_0000);
        run(OP_DIV, -32'sd7, 32'd2, "div -7/2");
        chk("div -7/2 const", Rc, 64'hFFFF_FFFF_FFFF_FFFD);
        run(OP_DIV, 32'd7, -32'sd2, "div 7/-2");
        chk("div 7/-2 const", Rc, 64'h0000_0001_FFFF_FFFD);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div minneg/-1");
        run(OP_DIV, 32'd5, 32'd0, "div 5/0");
        chk("div 5/0 const", Rc, 64'h0000_0005_FFFF_FFFF);

        // the next accepted Mul clears div_zero as soon as it is accepted
        issue(OP_MUL, 32'd3, 32'd4);
        chk("dz cleared", 64'(div_zero), 64'd0);
        wait_done("mul after dz");
        chk("mul after dz rc", Rc, 64'd12);
        last_rc = 64'd12;

        // unsupported opcode is ignored
        issue(5'b00001, 32'd9, 32'd9);
        ok = 1'b1;
        repeat (5) begin
            if (busy || done) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("bad op idle", 64'(ok), 64'd1);
        chk("bad op rc", Rc, last_rc);

        // a start while busy is ignored
        issue(OP_MUL, 32'd1000, -32'sd77);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; opcode = OP_DIV; Ra = 32'd50; Rb = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("mul overlap");
        chk("mul overlap lat", 64'(cyc - n0), 64'(MUL_LAT));
        chk("mul overlap rc", Rc, model(OP_MUL, 32'd1000, -32'sd77));
        last_rc = Rc;
        @(posedge clk);
        #1;
        chk("overlap no 2nd", 64'(busy | done), 64'd0);

        // clr in the middle of a Div aborts it, then a Div follows at once
        issue(OP_DIV, 32'd12345, 32'd11);
        ok = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) ok = 1'b0;
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        if (done) ok = 1'b0;
        chk("clr busy", 64'(busy), 64'd0);
        chk("clr rc", Rc, 64'd0);
        chk("clr no done", 64'(ok), 64'd1);
        last_rc = '0;
        run(OP_DIV, 32'd100, 32'd7, "div 100/7");
        chk("div 100/7 const", Rc, 64'h0000_0002_0000_000E);

        // random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = 32'($signed(5'($urandom)));
            if (i % 6 == 3) a = 32'h8000_0000;
            run((i % 2 == 0) ? OP_MUL : OP_DIV, a, b, (i % 2 == 0) ? "rnd mul" : "rnd div");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
